// File: rtl/posit8_decoded_mul_seq.sv
// Sequential radix-2 shift-add multiplier for decoded posit8 (es=0) operands.
// Produces an unrounded, normalized product for the encode/round stage.
module posit8_decoded_mul_seq #(
   parameter int SIG_W   = 6,
   parameter int SCALE_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 a_sign,
   input  logic [SCALE_W-1:0]   a_scale,
   input  logic [SIG_W-1:0]     a_sig,
   input  logic                 a_zero,
   input  logic                 a_nar,
   input  logic                 b_sign,
   input  logic [SCALE_W-1:0]   b_scale,
   input  logic [SIG_W-1:0]     b_sig,
   input  logic                 b_zero,
   input  logic                 b_nar,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 p_sign,
   output logic [SCALE_W:0]     p_scale,
   output logic [2*SIG_W-1:0]   p_sig,
   output logic                 p_zero,
   output logic                 p_nar
);

   localparam int PROD_W = 2 * SIG_W;
   localparam int CNT_W  = $clog2(SIG_W + 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      NORM,
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic [PROD_W-1:0]   mcand_q, mcand_d;
   logic [SIG_W-1:0]    mplier_q, mplier_d;
   logic [PROD_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                sign_q, sign_d;
   logic [SCALE_W:0]    scaleSum_q, scaleSum_d;
   logic                pSign_q, pSign_d;
   logic [SCALE_W:0]    pScale_q, pScale_d;
   logic [PROD_W-1:0]   pSig_q, pSig_d;
   logic                pZero_q, pZero_d;
   logic                pNar_q, pNar_d;

   logic                accept;
   logic                anyNar;
   logic                anyZero;
   logic [SCALE_W:0]    scaleSumIn;

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign accept     = in_valid && in_ready;
   assign anyNar     = a_nar || b_nar;
   assign anyZero    = a_zero || b_zero;
   assign scaleSumIn = {a_scale[SCALE_W-1], a_scale} + {b_scale[SCALE_W-1], b_scale};

   assign p_sign  = pSign_q;
   assign p_scale = pScale_q;
   assign p_sig   = pSig_q;
   assign p_zero  = pZero_q;
   assign p_nar   = pNar_q;

   // The multiplicand is pre-shifted and the multiplier shifted right each BUSY
   // cycle, which is the same as testing bit[cnt] and adding multiplicand<<cnt.
   always_comb begin
      state_d    = state_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      sign_d     = sign_q;
      scaleSum_d = scaleSum_q;
      pSign_d    = pSign_q;
      pScale_d   = pScale_q;
      pSig_d     = pSig_q;
      pZero_d    = pZero_q;
      pNar_d     = pNar_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               mcand_d    = {{SIG_W{1'b0}}, a_sig};
               mplier_d   = b_sig;
               sign_d     = a_sign ^ b_sign;
               scaleSum_d = scaleSumIn;
               if (anyNar) begin
                  pSign_d  = 1'b1;
                  pScale_d = '0;
                  pSig_d   = '0;
                  pZero_d  = 1'b0;
                  pNar_d   = 1'b1;
                  state_d  = DONE;
               end else if (anyZero) begin
                  pSign_d  = 1'b0;
                  pScale_d = '0;
                  pSig_d   = '0;
                  pZero_d  = 1'b1;
                  pNar_d   = 1'b0;
                  state_d  = DONE;
               end else begin
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = BUSY;
               end
            end
         end

         BUSY: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(SIG_W - 1)) begin
               state_d = NORM;
            end
         end

         NORM: begin
            // Product of two [1,2) significands lies in [1,4): at most one shift.
            if (acc_q[PROD_W-1]) begin
               pSig_d   = acc_q;
               pScale_d = scaleSum_q + (SCALE_W+1)'(1);
            end else begin
               pSig_d   = acc_q << 1;
               pScale_d = scaleSum_q;
            end
            pSign_d = sign_q;
            pZero_d = 1'b0;
            pNar_d  = 1'b0;
            state_d = DONE;
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         sign_q     <= 1'b0;
         scaleSum_q <= '0;
         pSign_q    <= 1'b0;
         pScale_q   <= '0;
         pSig_q     <= '0;
         pZero_q    <= 1'b0;
         pNar_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         sign_q     <= sign_d;
         scaleSum_q <= scaleSum_d;
         pSign_q    <= pSign_d;
         pScale_q   <= pScale_d;
         pSig_q     <= pSig_d;
         pZero_q    <= pZero_d;
         pNar_q     <= pNar_d;
      end
   end

endmodule

// File: tb/tb_posit8_decoded_mul_seq.sv
// Bench for posit8_decoded_mul_seq: directed operand pairs, an arithmetic
// reference model with an expected-result queue, and hand-computed literals.
module tb_posit8_decoded_mul_seq;

   localparam int SIG_W   = 6;
   localparam int SCALE_W = 4;

   typedef struct packed {
      logic                sign;
      logic [SCALE_W-1:0]  scale;
      logic [SIG_W-1:0]    sig;
      logic                zero;
      logic                nar;
   } opnd_t;

   typedef struct packed {
      logic                sign;
      logic [SCALE_W:0]    scale;
      logic [2*SIG_W-1:0]  sig;
      logic                zero;
      logic                nar;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic inValid = 1'b0;
   logic outReady = 1'b0;
   opnd_t opA = '0;
   opnd_t opB = '0;

   logic                inReady;
   logic                outValid;
   logic                pSign;
   logic [SCALE_W:0]    pScale;
   logic [2*SIG_W-1:0]  pSig;
   logic                pZero;
   logic                pNar;

   int checks = 0;
   int failures = 0;
   res_t expQ[$];

   posit8_decoded_mul_seq #(.SIG_W(SIG_W), .SCALE_W(SCALE_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .a_sign    (opA.sign),
      .a_scale   (opA.scale),
      .a_sig     (opA.sig),
      .a_zero    (opA.zero),
      .a_nar     (opA.nar),
      .b_sign    (opB.sign),
      .b_scale   (opB.scale),
      .b_sig     (opB.sig),
      .b_zero    (opB.zero),
      .b_nar     (opB.nar),
      .out_valid (outValid),
      .out_ready (outReady),
      .p_sign    (pSign),
      .p_scale   (pScale),
      .p_sig     (pSig),
      .p_zero    (pZero),
      .p_nar     (pNar)
   );

   always #5 clk = ~clk;

   // Reference: real-valued product of two [1,2) significands, renormalized.
   function automatic res_t model(input opnd_t a, input opnd_t b);
      res_t r;
      int prod;
      int sc;
      r = '0;
      if (a.nar || b.nar) begin
         r.nar  = 1'b1;
         r.sign = 1'b1;
      end else if (a.zero || b.zero) begin
         r.zero = 1'b1;
      end else begin
         prod = int'(a.sig) * int'(b.sig);
         sc   = int'($signed(a.scale)) + int'($signed(b.scale));
         if (prod >= (1 << (2*SIG_W-1))) begin
            sc = sc + 1;
         end else begin
            prod = prod * 2;
         end
         r.sig   = (2*SIG_W)'(prod);
         r.scale = (SCALE_W+1)'(sc);
         r.sign  = a.sign ^ b.sign;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
      end
   endtask

   // Scoreboard bookkeeping: push on every accept, pop on every output handshake.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         expQ.delete();
      end else begin
         if (outValid && outReady && expQ.size() > 0) begin
            void'(expQ.pop_front());
         end
         if (inValid && inReady) begin
            expQ.push_back(model(opA, opB));
         end
      end
   end

   // Every cycle with a valid result, the outputs must equal the head of the queue.
   always @(negedge clk) begin
      if (!rst && outValid) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_out_valid", 32'(outValid), 32'd0);
         end else begin
            checkOutput("model_result", 32'({pSign, pScale, pSig, pZero, pNar}),
                        32'(expQ[0]));
         end
      end
   end

   function automatic opnd_t mk(input logic s, input logic [SCALE_W-1:0] sc,
                                input logic [SIG_W-1:0] sg, input logic z,
                                input logic n);
      opnd_t o;
      o.sign = s; o.scale = sc; o.sig = sg; o.zero = z; o.nar = n;
      return o;
   endfunction

   // Present an operand pair and wait (bounded) for the accept edge; returns #1 after it.
   task automatic applyStimulus(input opnd_t a, input opnd_t b);
      bit accepted;
      accepted = 1'b0;
      opA = a;
      opB = b;
      inValid = 1'b1;
      for (int i = 0; i < 20 && !accepted; i++) begin
         if (inReady) accepted = 1'b1;
         @(posedge clk);
         #1;
      end
      inValid = 1'b0;
      checkOutput("accept", 32'(accepted), 32'd1);
   endtask

   // Latency counts the accept edge as 1.
   task automatic waitResult(input string name, input int expLat);
      int lat;
      lat = 1;
      while (!outValid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput(name, 32'(lat), 32'(expLat));
   endtask

   task automatic releaseResult();
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      checkOutput("release_out_valid", 32'(outValid), 32'd0);
      checkOutput("release_in_ready", 32'(inReady), 32'd1);
   endtask

   initial begin
      res_t held;
      opnd_t one;
      one = mk(1'b0, 4'd0, 6'b100000, 1'b0, 1'b0);

      #2 rst = 1'b1;
      #2;
      checkOutput("reset_in_ready", 32'(inReady), 32'd1);
      checkOutput("reset_out_valid", 32'(outValid), 32'd0);
      checkOutput("reset_outputs", 32'({pSign, pScale, pSig, pZero, pNar}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1.0 x 1.0
      applyStimulus(one, one);
      waitResult("lat_one", 8);
      checkOutput("one_sig", 32'(pSig), 32'h800);
      checkOutput("one_scale", 32'(pScale), 32'h0);
      checkOutput("one_sign", 32'(pSign), 32'd0);
      releaseResult();

      // 1.5 x 1.5, scales +2/-3, signs 1/0
      applyStimulus(mk(1'b1, 4'sd2, 6'b110000, 1'b0, 1'b0),
                    mk(1'b0, -4'sd3, 6'b110000, 1'b0, 1'b0));
      waitResult("lat_1p5", 8);
      checkOutput("onehalf_sig", 32'(pSig), 32'h900);
      checkOutput("onehalf_scale", 32'(pScale), 32'h0);
      checkOutput("onehalf_sign", 32'(pSign), 32'd1);
      releaseResult();

      // Largest significands and scales
      applyStimulus(mk(1'b0, 4'sd6, 6'b111111, 1'b0, 1'b0),
                    mk(1'b1, 4'sd6, 6'b111111, 1'b0, 1'b0));
      waitResult("lat_max", 8);
      checkOutput("max_sig", 32'(pSig), 32'hF81);
      checkOutput("max_scale", 32'(pScale), 32'd13);
      releaseResult();

      // Most negative scales
      applyStimulus(mk(1'b0, -4'sd6, 6'b100000, 1'b0, 1'b0),
                    mk(1'b0, -4'sd6, 6'b100000, 1'b0, 1'b0));
      waitResult("lat_min", 8);
      checkOutput("min_scale", 32'(pScale), 32'(5'b10100));
      checkOutput("min_sig", 32'(pSig), 32'h800);
      releaseResult();

      // Non-power-of-two significands, both normalization branches
      applyStimulus(mk(1'b1, 4'sd1, 6'b101000, 1'b0, 1'b0),
                    mk(1'b1, -4'sd1, 6'b111000, 1'b0, 1'b0));
      waitResult("lat_mixA", 8);
      releaseResult();
      applyStimulus(mk(1'b0, 4'sd3, 6'b100001, 1'b0, 1'b0),
                    mk(1'b1, 4'sd2, 6'b100011, 1'b0, 1'b0));
      waitResult("lat_mixB", 8);
      checkOutput("mixB_sig", 32'(pSig), 32'h906);
      releaseResult();

      // NaR x 0: NaR wins
      applyStimulus(mk(1'b0, 4'd0, 6'd0, 1'b0, 1'b1), mk(1'b0, 4'd0, 6'd0, 1'b1, 1'b0));
      waitResult("lat_nar", 1);
      checkOutput("nar_flags", 32'({pNar, pSign, pZero}), 32'b110);
      checkOutput("nar_value", 32'({pScale, pSig}), 32'd0);
      releaseResult();

      // Zero only
      applyStimulus(mk(1'b1, 4'sd3, 6'd0, 1'b1, 1'b0), mk(1'b1, 4'sd2, 6'b110000, 1'b0, 1'b0));
      waitResult("lat_zero", 1);
      checkOutput("zero_fields", 32'({pSign, pScale, pSig, pZero, pNar}), 32'd2);
      releaseResult();

      // Backpressure, with a new operand waiting upstream the whole time
      applyStimulus(mk(1'b1, 4'sd1, 6'b110000, 1'b0, 1'b0), one);
      waitResult("lat_bp", 8);
      held = {pSign, pScale, pSig, pZero, pNar};
      opA = mk(1'b0, 4'sd1, 6'b101000, 1'b0, 1'b0);
      opB = one;
      inValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("bp_out_valid", 32'(outValid), 32'd1);
         checkOutput("bp_in_ready", 32'(inReady), 32'd0);
         checkOutput("bp_stable", 32'({pSign, pScale, pSig, pZero, pNar}), 32'(held));
      end
      releaseResult();
      @(posedge clk);
      #1;
      inValid = 1'b0;
      checkOutput("bp_new_accept", 32'(inReady), 32'd0);
      waitResult("lat_bp_next", 8);
      checkOutput("bp_next_sig", 32'(pSig), 32'hA00);
      releaseResult();

      // Reset in the third BUSY cycle abandons the operation
      applyStimulus(mk(1'b0, 4'sd2, 6'b111111, 1'b0, 1'b0), one);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("midrst_in_ready", 32'(inReady), 32'd1);
      checkOutput("midrst_out_valid", 32'(outValid), 32'd0);
      checkOutput("midrst_outputs", 32'({pSign, pScale, pSig, pZero, pNar}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("postrst_out_valid", 32'(outValid), 32'd0);
      applyStimulus(one, one);
      waitResult("lat_postrst", 8);
      checkOutput("postrst_sig", 32'(pSig), 32'h800);
      releaseResult();

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/posit8_decoded_mul_seq.md
Name: posit8_decoded_mul_seq

Overview:
- Multicycle multiplier that consumes two decoded posit8 (es=0) operands from the regime/exponent decode stage.
- Produces an unrounded, normalized decoded product for the downstream posit encode/round stage.
- Uses a radix-2 shift-add datapath: one multiplier bit per cycle.
- Valid/ready handshake on input and output, so it can stall against either neighbour.

Parameters:
- SIG_W, 6, significand width including hidden bit (1.fffff).
- SCALE_W, 4, input scale width, two's complement (posit8 es=0 range -6..+6).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a_sign  input  1  sign of operand A.
- a_scale  input  SCALE_W  two's complement power-of-two scale of A.
- a_sig  input  SIG_W  significand of A; MSB is the hidden 1 for finite nonzero.
- a_zero  input  1  A is zero.
- a_nar  input  1  A is NaR.
- b_sign, b_scale, b_sig, b_zero, b_nar  input  same widths as A  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- p_sign  output  1  product sign.
- p_scale  output  SCALE_W+1  two's complement product scale.
- p_sig  output  2*SIG_W  normalized product significand; MSB=1 when finite nonzero.
- p_zero  output  1  product is zero.
- p_nar  output  1  product is NaR.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high on rst.
- Reset:
  - State goes to IDLE.
  - in_ready=1, out_valid=0.
  - All p_* outputs, the accumulator and the iteration counter clear to 0.
  - Reset asserted mid-operation abandons the operation; no result is produced.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register operands, sign=a_sign^b_sign and scale_sum=sext(a_scale)+sext(b_scale).
  - If either special flag is set, go to DONE; otherwise clear the accumulator and counter, then go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, if multiplier bit[cnt] (LSB first) is 1, add the multiplicand shifted left by cnt into the 2*SIG_W accumulator; then cnt++.
  - After exactly SIG_W cycles, go to NORM.
- NORM (1 cycle):
  - If acc[2*SIG_W-1]=1: p_sig=acc, p_scale=scale_sum+1.
  - Else: p_sig=acc<<1, p_scale=scale_sum.
  - Go to DONE.
- DONE:
  - out_valid=1.
  - Outputs are held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE with out_valid=0 the next cycle.
  - in_ready=0 in DONE, so there is no same-cycle accept.
- Latency:
  - Finite path: accept edge, then SIG_W BUSY cycles, then 1 NORM cycle. out_valid rises SIG_W+2 cycles after the accept edge (8 for defaults).
  - Special path: out_valid rises 1 cycle after accept.
- Specials:
  - NaR dominates: if a_nar or b_nar, then p_nar=1, p_sign=1, p_scale=0, p_sig=0, p_zero=0. This includes NaR×0.
  - Else if a_zero or b_zero: p_zero=1, p_sign=0, p_scale=0, p_sig=0.
  - Special results never assert both p_zero and p_nar.
- Finite results have p_zero=p_nar=0.
- Arithmetic:
  - Operands lie in [1,2), so the product lies in [1,4).
  - The scale adder is SCALE_W+1 bits wide, so it never overflows (range -12..+13).
  - No rounding or saturation here; that is owned by the encode stage.
- in_valid while busy is ignored. The upstream stage must hold operands until in_ready.
- out_ready while out_valid=0 has no effect.

Test Plan:
- 1.0×1.0: a_sig=b_sig=6'b100000, scales 0/0 -> after 8 cycles, p_sig=12'h800, p_scale=0, p_sign=0.
- 1.5×1.5, scales +2/-3, signs 1/0 -> p_sig=12'h900, p_scale=0 (normalization increments -1 to 0), p_sign=1.
- Extremes: a_sig=b_sig=6'b111111, scales +6/+6 -> p_sig=12'hF81, p_scale=+13. Scales -6/-6 with 1.0×1.0 -> p_scale=-12 (5'b10100).
- Specials:
  - a_nar=1, b_zero=1 -> out_valid 1 cycle after accept, p_nar=1, p_sign=1, p_zero=0.
  - a_zero only -> p_zero=1, all other fields 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout. Assert out_ready -> next cycle out_valid=0, in_ready=1, and a new operand is accepted.
- Reset mid-BUSY: assert rst on cycle 3 of BUSY -> immediately in_ready=1, out_valid=0, outputs 0. After release, a fresh 1.0×1.0 yields 12'h800.
